// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Serial transmit stage of the UART. Accepts one byte per valid/ready
//   handshake and sends it as: start bit (0), 8 data bits MSB first,
//   optional even-parity bit, stop bit (1). The first data bit lands in the
//   receiver's shift-register MSB and the parity bit in its LSB.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//
// Ports
//   clk       in   transmit clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   tx_data   in   [7:0] byte to send, sampled at accept
//   tx_valid  in   upstream has a byte on tx_data
//   parity_en in   append even-parity bit, sampled at accept
//   tx_ready  out  idle and able to accept (combinational from state)
//   tx_out    out  registered serial line, idle high
//   busy      out  frame in progress (= !tx_ready)
//   done      out  one-cycle pulse in the first idle cycle after a stop bit
module uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       parity_en,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          par_en_q;
    logic          par_q;
    logic          tx_out_q;
    logic          done_q;

    logic          baud_tc;
    logic          accept;
    logic          line_c;

    assign baud_tc  = (baud_q == BAUD_LAST);
    assign tx_ready = (state_q == IDLE);
    assign busy     = !tx_ready;
    assign accept   = tx_ready && tx_valid;
    assign tx_out   = tx_out_q;
    assign done     = done_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (tx_valid) state_d = START;
            START:  if (baud_tc)  state_d = DATA;
            DATA:   if (baud_tc && (bit_q == 3'd7))
                        state_d = par_en_q ? PARITY : STOP;
            PARITY: if (baud_tc)  state_d = STOP;
            STOP:   if (baud_tc)  state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Line level for the current state; registered into tx_out so the line
    // trails the FSM by one cycle (start bit appears the edge after accept).
    always_comb begin
        line_c = 1'b1;
        case (state_q)
            IDLE:    line_c = 1'b1;
            START:   line_c = 1'b0;
            DATA:    line_c = shift_q[7];
            PARITY:  line_c = par_q;
            STOP:    line_c = 1'b1;
            default: line_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            tx_out_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;

            // Baud counter restarts on every state change and holds at 0 in IDLE
            if ((state_d != state_q) || baud_tc || (state_q == IDLE))
                baud_q <= '0;
            else
                baud_q <= baud_q + CW'(1);

            if (accept) begin
                shift_q  <= tx_data;
                par_en_q <= parity_en;
                par_q    <= ^tx_data;
                bit_q    <= '0;
            end else if ((state_q == DATA) && baud_tc) begin
                shift_q <= {shift_q[6:0], 1'b0};
                bit_q   <= bit_q + 3'd1;
            end

            tx_out_q <= line_c;
            // Registered so it lands in the first IDLE cycle
            done_q   <= (state_q == STOP) && baud_tc;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

    localparam int unsigned CPB = 4;

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       parity_en;
    logic       tx_ready;
    logic       tx_out;
    logic       busy;
    logic       done;

    uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .parity_en (parity_en),
        .tx_ready  (tx_ready),
        .tx_out    (tx_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges seen so far
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  d;
        logic        p;
        int unsigned acc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    bit          mon_active  = 1'b0;
    int unsigned last_done_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge, pops an expected
    // frame when the line drops to a start bit and checks it cycle by cycle.
    initial begin
        exp_t        e;
        logic        bits[0:10];
        int unsigned nb;
        int unsigned k;
        nb = 10;
        k  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                chk("reset_tx_out", 32'(tx_out), 32'd1);
                chk("reset_ready", 32'(tx_ready), 32'd1);
                chk("reset_busy", 32'(busy), 32'd0);
                chk("reset_done", 32'(done), 32'd0);
                mon_active = 1'b0;
            end else begin
                chk("busy_vs_ready", 32'(busy), 32'(!tx_ready));
                if (!mon_active) begin
                    chk("done_idle", 32'(done), 32'd0);
                    if (tx_out == 1'b0) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_frame", 32'(tx_out), 32'd1);
                        end else begin
                            e = exp_q.pop_front();
                            bits[0] = 1'b0;
                            for (int i = 0; i < 8; i++) bits[1 + i] = e.d[7 - i];
                            if (e.p) begin
                                bits[9]  = ^e.d;
                                bits[10] = 1'b1;
                                nb = 11;
                            end else begin
                                bits[9]  = 1'b1;
                                bits[10] = 1'b1;
                                nb = 10;
                            end
                            chk("start_latency", cyc, e.acc + 1);
                            mon_active = 1'b1;
                            k = 0;
                        end
                    end
                end
                if (mon_active) begin
                    chk("frame_bit", 32'(tx_out), 32'(bits[k / CPB]));
                    chk("done_timing", 32'(done), 32'(k == nb * CPB - 1));
                    if (k == nb * CPB - 1) begin
                        mon_active    = 1'b0;
                        last_done_cyc = cyc;
                    end else begin
                        k++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic p, input bit hold,
                        output int unsigned acc);
        int unsigned n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        acc = 0;
        @(negedge clk);
        tx_data   = d;
        parity_en = p;
        tx_valid  = 1'b1;
        while (!ok && n < 300) begin
            if (tx_ready) begin
                ok  = 1'b1;
                acc = cyc + 1;
                exp_q.push_back('{d, p, acc});
            end
            @(negedge clk);
            n++;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        if (!hold) tx_valid = 1'b0;
        // Scramble inputs after accept; the frame in flight must not change
        tx_data   = 8'($urandom);
        parity_en = 1'($urandom);
    endtask

    initial begin
        int unsigned acc1;
        int unsigned acc2;
        int unsigned n;
        reset_n   = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        parity_en = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tx_data   = 8'($urandom);
            tx_valid  = 1'($urandom);
            parity_en = 1'($urandom);
            #1;
            chk("rst_tx_out", 32'(tx_out), 32'd1);
            chk("rst_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        reset_n  = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_line", 32'(tx_out), 32'd1);

        // Directed frames
        send(8'hA5, 1'b0, 1'b0, acc1);
        send(8'hA5, 1'b1, 1'b0, acc1);
        send(8'h07, 1'b1, 1'b0, acc1);

        // Back-to-back with valid held high
        send(8'h00, 1'b0, 1'b1, acc1);
        send(8'hFF, 1'b0, 1'b0, acc2);
        chk("b2b_accept_in_done_cycle", acc2, last_done_cyc + 1);

        // Valid pulsed mid-frame with new data is ignored
        send(8'h5A, 1'b1, 1'b0, acc1);
        repeat (10) @(negedge clk);
        tx_data   = 8'h3C;
        parity_en = 1'b0;
        tx_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("ready_while_busy", 32'(tx_ready), 32'd0);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        send(8'h3C, 1'b0, 1'b0, acc1);

        // Reset during data bit 3, then a clean frame
        send(8'h96, 1'b1, 1'b0, acc1);
        while (cyc < acc1 + 1 + 4 * CPB + 1) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async_reset_tx_out", 32'(tx_out), 32'd1);
        chk("async_reset_ready", 32'(tx_ready), 32'd1);
        chk("async_reset_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        send(8'h81, 1'b0, 1'b0, acc1);

        // Random traffic
        for (int i = 0; i < 25; i++) begin
            bit hold;
            hold = 1'($urandom_range(0, 1));
            send(8'($urandom), 1'($urandom), hold, acc1);
            if (!hold) repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        tx_valid = 1'b0;

        // Drain
        n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 32'd0, 32'd1);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
